// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder
// Brief    : Debounced button level -> single-cycle press/release/click/
//            double-click/long-press/auto-repeat event pulses.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_decoder #(
   parameter int   CLOCK_FREQUENCY   = 50,
   parameter int   LONG_PRESS_TIME   = 1000,
   parameter int   REPEAT_PERIOD     = 200,
   parameter int   DOUBLE_CLICK_TIME = 300,
   parameter logic ACTIVE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic btn_level,
   output logic btn_held,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic double_click_pulse,
   output logic long_press_pulse,
   output logic repeat_pulse
);

   localparam int c_LONG_N  = LONG_PRESS_TIME   * CLOCK_FREQUENCY * 1000;
   localparam int c_REP_N   = REPEAT_PERIOD     * CLOCK_FREQUENCY * 1000;
   localparam int c_DBL_N   = DOUBLE_CLICK_TIME * CLOCK_FREQUENCY * 1000;
   localparam int c_MAX_LR  = (c_LONG_N > c_REP_N) ? c_LONG_N : c_REP_N;
   localparam int c_MAX_N   = (c_MAX_LR > c_DBL_N) ? c_MAX_LR : c_DBL_N;
   localparam int c_CNT_W   = $clog2(c_MAX_N + 1);

   localparam logic [c_CNT_W-1:0] c_LONG_TC = c_CNT_W'(c_LONG_N - 1);
   localparam logic [c_CNT_W-1:0] c_REP_TC  = c_CNT_W'(c_REP_N - 1);
   localparam logic [c_CNT_W-1:0] c_DBL_TC  = c_CNT_W'(c_DBL_N - 1);

   typedef enum logic [2:0] {
      ST_LOCKOUT     = 3'd0,
      ST_IDLE        = 3'd1,
      ST_PRESSED     = 3'd2,
      ST_HELD        = 3'd3,
      ST_WAIT_SECOND = 3'd4,
      ST_SECOND      = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_CNT_W-1:0]   w_cnt_nxt;
   logic [c_CNT_W-1:0]   w_cnt_inc;
   logic                 w_pressed;

   logic r_btn_held, r_press, r_release, r_click, r_double, r_long, r_repeat;
   logic w_btn_held, w_press, w_release, w_click, w_double, w_long, w_repeat;

   assign w_pressed = (btn_level == ACTIVE_LEVEL);
   // Saturating increment: the counter must never wrap back to a terminal value.
   assign w_cnt_inc = (r_cnt == {c_CNT_W{1'b1}}) ? r_cnt : r_cnt + c_CNT_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_cnt_inc;
      w_btn_held  = w_pressed && (r_state != ST_LOCKOUT);
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_click     = 1'b0;
      w_double    = 1'b0;
      w_long      = 1'b0;
      w_repeat    = 1'b0;

      case (r_state)
         ST_LOCKOUT: begin
            w_cnt_nxt = '0;
            if (!w_pressed) w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_pressed) begin
               w_press     = 1'b1;
               w_state_nxt = ST_PRESSED;
            end
         end
         ST_PRESSED: begin
            if (!w_pressed) begin
               w_release   = 1'b1;
               w_state_nxt = ST_WAIT_SECOND;
            end else if (r_cnt == c_LONG_TC) begin
               w_long      = 1'b1;
               w_state_nxt = ST_HELD;
            end
         end
         ST_HELD: begin
            if (!w_pressed) begin
               w_release   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == c_REP_TC) begin
               w_repeat  = 1'b1;
               w_cnt_nxt = '0;
            end
         end
         ST_WAIT_SECOND: begin
            if (w_pressed) begin
               w_press     = 1'b1;
               w_state_nxt = ST_SECOND;
            end else if (r_cnt == c_DBL_TC) begin
               w_click     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SECOND: begin
            if (!w_pressed) begin
               w_release   = 1'b1;
               w_double    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == c_LONG_TC) begin
               // The pending first click is still owed when the second press turns long.
               w_click     = 1'b1;
               w_long      = 1'b1;
               w_state_nxt = ST_HELD;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_LOCKOUT;
         end
      endcase

      if (w_state_nxt != r_state) w_cnt_nxt = '0;

      if (!enable) begin
         w_state_nxt = ST_LOCKOUT;
         w_cnt_nxt   = '0;
         w_btn_held  = 1'b0;
         w_press     = 1'b0;
         w_release   = 1'b0;
         w_click     = 1'b0;
         w_double    = 1'b0;
         w_long      = 1'b0;
         w_repeat    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_LOCKOUT;
         r_cnt      <= '0;
         r_btn_held <= 1'b0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_click    <= 1'b0;
         r_double   <= 1'b0;
         r_long     <= 1'b0;
         r_repeat   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_btn_held <= w_btn_held;
         r_press    <= w_press;
         r_release  <= w_release;
         r_click    <= w_click;
         r_double   <= w_double;
         r_long     <= w_long;
         r_repeat   <= w_repeat;
      end
   end

   assign btn_held           = r_btn_held;
   assign press_pulse        = r_press;
   assign release_pulse      = r_release;
   assign click_pulse        = r_click;
   assign double_click_pulse = r_double;
   assign long_press_pulse   = r_long;
   assign repeat_pulse       = r_repeat;

endmodule
`default_nettype wire
